mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 es_to_ms_valid  in  1  execute stage presents an instruction.
REQ-005 es_rf_collect  in  39  {res_from_mem, rf_we, rf_waddr[4:0], ex_result[31:0]}; ex_result is the ALU/mul/div result, or the byte address for loads.
REQ-006 es_pc  in  32  PC of the presented instruction.
REQ-007 es_mem_inst_bus  in  5  load type {ld_b, ld_bu, ld_h, ld_hu, ld_w}, bit4..bit0.
REQ-008 data_sram_rdata  in  32  read word from data SRAM, valid in the first cycle after the load entered this stage.
REQ-009 ws_allowin  in  1  writeback stage can accept.
REQ-010 ms_allowin  out  1  this stage can accept from execute.
REQ-011 ms_to_ws_valid  out  1  instruction handed to writeback.
REQ-012 ms_to_ws_bus  out  70  {ms_rf_we, ms_rf_waddr[4:0], ms_final_result[31:0], ms_pc[31:0]}.
REQ-013 ms_rf_collect  out  38  forwarding: {ms_rf_we & ms_valid, ms_rf_waddr, ms_final_result}.

Function
REQ-014 ms_ready_go SHALL be constant 1.
REQ-015 ms_allowin = ~ms_valid | ws_allowin; ms_to_ws_valid = ms_valid.
REQ-016 When ms_allowin=1, ms_valid SHALL load es_to_ms_valid; otherwise hold.
REQ-017 On es_to_ms_valid & ms_allowin, SHALL latch es_rf_collect, es_pc, es_mem_inst_bus; otherwise these registers hold.
REQ-018 first_cycle flag SHALL be set on the accept edge and cleared on the next edge.
REQ-019 While ms_valid & first_cycle, the load word SHALL be data_sram_rdata and SHALL also be captured into rdata_hold on that edge.
REQ-020 While ms_valid & ~first_cycle, the load word SHALL be rdata_hold; SRAM reads issued upstream during a stall SHALL NOT alter the result.
REQ-021 Alignment uses ex_result[1:0] = a. ld_b: sign-extend byte a. ld_bu: zero-extend byte a. ld_h: sign-extend half a[1]. ld_hu: zero-extend half a[1]. ld_w: whole word.
REQ-022 Type priority when several bits are set: ld_b > ld_bu > ld_h > ld_hu > ld_w; none set with res_from_mem=1 SHALL behave as ld_w.
REQ-023 ms_final_result = res_from_mem ? aligned load : ex_result.
REQ-024 Back-to-back: accept and handoff on the same edge are legal; a new accept SHALL set first_cycle again.
REQ-025 Stall (ms_valid=1, ws_allowin=0): all outputs stable, ms_allowin=0.
REQ-026 Bubble (ms_valid=0): ms_rf_collect[37]=0; ms_to_ws_bus contents don't-care but SHALL be the held registers.

Reset
REQ-027 resetn=0 at an edge: ms_valid, first_cycle, rdata_hold and all latched fields SHALL be 0; the in-flight instruction is discarded.
REQ-028 During and after reset until the next accept: ms_to_ws_valid=0, ms_allowin=1, ms_rf_collect=0, ms_to_ws_bus=0.

Verification
REQ-029 ALU pass-through: collect={0,1,5'd3,32'h1234_5678}, pc=32'h1c00_0000, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,3,32'h1234_5678,32'h1c00_0000}.
REQ-030 ld_b at a=3, rdata=32'h80FF_0011 -> final 32'hFFFF_FF80; ld_bu same -> 32'h0000_0080; ld_h at a=2 -> 32'hFFFF_80FF; ld_hu -> 32'h0000_80FF.
REQ-031 Stalled load: ld_w, rdata=32'hAAAA_AAAA in first cycle, ws_allowin=0 for 3 cycles while rdata changes to 32'h5555_5555 -> final stays 32'hAAAA_AAAA; ms_allowin=0 throughout; handoff when ws_allowin=1.
REQ-032 Back-to-back: two valid instructions on consecutive cycles with ws_allowin=1 -> two consecutive ms_to_ws_valid cycles, each with its own pc and result.
REQ-033 Reset mid-stall: ms_valid=1, ws_allowin=0, resetn=0 one edge -> ms_to_ws_valid=0, ms_rf_collect=0, ms_allowin=1 next cycle.
REQ-034 Bubble forwarding: es_to_ms_valid=0 with rf_we=1 on collect -> ms_rf_collect[37]=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Signal bundle between the memory stage and its neighbours (execute, writeback, data SRAM).
interface mem_stage_if;

   localparam int unsigned ES_RF_W = 39;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned INST_W  = 5;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned WS_BUS_W = 70;
   localparam int unsigned MS_RF_W = 38;

   logic                  es_to_ms_valid;
   logic [ES_RF_W-1:0]    es_rf_collect;
   logic [PC_W-1:0]       es_pc;
   logic [INST_W-1:0]     es_mem_inst_bus;
   logic [DATA_W-1:0]     data_sram_rdata;
   logic                  ws_allowin;
   logic                  ms_allowin;
   logic                  ms_to_ws_valid;
   logic [WS_BUS_W-1:0]   ms_to_ws_bus;
   logic [MS_RF_W-1:0]    ms_rf_collect;

   // Surrounding pipeline: drives execute-side inputs, SRAM data and writeback backpressure.
   modport master (
      output es_to_ms_valid,
      output es_rf_collect,
      output es_pc,
      output es_mem_inst_bus,
      output data_sram_rdata,
      output ws_allowin,
      input  ms_allowin,
      input  ms_to_ws_valid,
      input  ms_to_ws_bus,
      input  ms_rf_collect
   );

   // Memory stage view.
   modport slave (
      input  es_to_ms_valid,
      input  es_rf_collect,
      input  es_pc,
      input  es_mem_inst_bus,
      input  data_sram_rdata,
      input  ws_allowin,
      output ms_allowin,
      output ms_to_ws_valid,
      output ms_to_ws_bus,
      output ms_rf_collect
   );

endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds one instruction, aligns load data, forwards results.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   mem_stage_if.slave  bus
);

   localparam int unsigned ES_RF_W = 39;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned INST_W  = 5;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 5;

   // Stage occupancy and load-data bookkeeping.
   logic                ms_valid;
   logic                first_cycle;
   logic [DATA_W-1:0]   rdata_hold;

   // Latched instruction fields.
   logic [ES_RF_W-1:0]  rf_r;
   logic [PC_W-1:0]     pc_r;
   logic [INST_W-1:0]   inst_r;

   // Unpacked views of the latched fields.
   logic                res_from_mem;
   logic                rf_we;
   logic [ADDR_W-1:0]   rf_waddr;
   logic [DATA_W-1:0]   ex_result;
   logic [1:0]          byte_addr;

   // Combinational datapath signals.
   logic                ms_allowin_c;
   logic                accept_c;
   logic [DATA_W-1:0]   load_word_c;
   logic [7:0]          load_byte_c;
   logic [15:0]         load_half_c;
   logic [DATA_W-1:0]   aligned_c;
   logic [DATA_W-1:0]   final_result_c;

   assign res_from_mem = rf_r[38];
   assign rf_we        = rf_r[37];
   assign rf_waddr     = rf_r[36:32];
   assign ex_result    = rf_r[31:0];
   assign byte_addr    = ex_result[1:0];

   // Handshake: ready_go is always 1, so the stage drains whenever writeback accepts.
   always_comb begin
      ms_allowin_c = ~ms_valid | bus.ws_allowin;
      accept_c     = bus.es_to_ms_valid & ms_allowin_c;
   end

   // Occupancy flag and first-cycle marker; a fresh accept always re-arms first_cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid    <= 1'b0;
         first_cycle <= 1'b0;
      end else begin
         if (ms_allowin_c) begin
            ms_valid <= bus.es_to_ms_valid;
         end
         first_cycle <= accept_c;
      end
   end

   // Instruction field capture on accept; held otherwise.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rf_r   <= '0;
         pc_r   <= '0;
         inst_r <= '0;
      end else if (accept_c) begin
         rf_r   <= bus.es_rf_collect;
         pc_r   <= bus.es_pc;
         inst_r <= bus.es_mem_inst_bus;
      end
   end

   // SRAM data is only valid in the first cycle; keep a copy so stalls see a stable word.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_hold <= '0;
      end else if (ms_valid && first_cycle) begin
         rdata_hold <= bus.data_sram_rdata;
      end
   end

   // Pick the live SRAM word in the first cycle, the held copy afterwards.
   always_comb begin
      load_word_c = first_cycle ? bus.data_sram_rdata : rdata_hold;
   end

   // Byte and halfword extraction by address offset.
   always_comb begin
      load_byte_c = load_word_c[7:0];
      case (byte_addr)
         2'd0:    load_byte_c = load_word_c[7:0];
         2'd1:    load_byte_c = load_word_c[15:8];
         2'd2:    load_byte_c = load_word_c[23:16];
         default: load_byte_c = load_word_c[31:24];
      endcase
      load_half_c = byte_addr[1] ? load_word_c[31:16] : load_word_c[15:0];
   end

   // Load type decode with fixed priority ld_b > ld_bu > ld_h > ld_hu > word.
   always_comb begin
      aligned_c = load_word_c;
      if (inst_r[4]) begin
         aligned_c = {{24{load_byte_c[7]}}, load_byte_c};
      end else if (inst_r[3]) begin
         aligned_c = {24'h00_0000, load_byte_c};
      end else if (inst_r[2]) begin
         aligned_c = {{16{load_half_c[15]}}, load_half_c};
      end else if (inst_r[1]) begin
         aligned_c = {16'h0000, load_half_c};
      end
   end

   // Result select: memory data for loads, execute result otherwise.
   always_comb begin
      final_result_c = res_from_mem ? aligned_c : ex_result;
   end

   // Output buses built from held registers; forwarding write-enable qualified by valid.
   assign bus.ms_allowin     = ms_allowin_c;
   assign bus.ms_to_ws_valid = ms_valid;
   assign bus.ms_to_ws_bus   = {rf_we, rf_waddr, final_result_c, pc_r};
   assign bus.ms_rf_collect  = {rf_we & ms_valid, rf_waddr, final_result_c};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   mem_stage_if bus_if ();

   mem_stage dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [38:0] rf, input logic [31:0] pc, input logic [4:0] inst);
      bus_if.es_to_ms_valid  = 1'b1;
      bus_if.es_rf_collect   = rf;
      bus_if.es_pc           = pc;
      bus_if.es_mem_inst_bus = inst;
   endtask

   task automatic idle();
      bus_if.es_to_ms_valid = 1'b0;
   endtask

   logic [4:0]  ld_inst [9];
   logic [1:0]  ld_off  [9];
   logic [31:0] ld_exp  [9];

   initial begin
      checks = 0;
      errors = 0;
      // load vectors against rdata 32'h80FF_0011
      ld_inst[0] = 5'b10000; ld_off[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
      ld_inst[1] = 5'b01000; ld_off[1] = 2'd3; ld_exp[1] = 32'h0000_0080;
      ld_inst[2] = 5'b00100; ld_off[2] = 2'd2; ld_exp[2] = 32'hFFFF_80FF;
      ld_inst[3] = 5'b00010; ld_off[3] = 2'd2; ld_exp[3] = 32'h0000_80FF;
      ld_inst[4] = 5'b00001; ld_off[4] = 2'd1; ld_exp[4] = 32'h80FF_0011;
      ld_inst[5] = 5'b11111; ld_off[5] = 2'd3; ld_exp[5] = 32'hFFFF_FF80;
      ld_inst[6] = 5'b00000; ld_off[6] = 2'd0; ld_exp[6] = 32'h80FF_0011;
      ld_inst[7] = 5'b01000; ld_off[7] = 2'd2; ld_exp[7] = 32'h0000_00FF;
      ld_inst[8] = 5'b00110; ld_off[8] = 2'd0; ld_exp[8] = 32'h0000_0011;

      resetn                 = 1'b0;
      bus_if.es_to_ms_valid  = 1'b0;
      bus_if.es_rf_collect   = '0;
      bus_if.es_pc           = '0;
      bus_if.es_mem_inst_bus = '0;
      bus_if.data_sram_rdata = '0;
      bus_if.ws_allowin      = 1'b1;

      // reset state
      repeat (2) step();
      #1;
      check("rst_valid",   bus_if.ms_to_ws_valid, 1'b0);
      check("rst_allowin", bus_if.ms_allowin, 1'b1);
      check("rst_fwd",     bus_if.ms_rf_collect, 38'h0);
      check("rst_bus",     bus_if.ms_to_ws_bus, 70'h0);
      resetn = 1'b1;
      step();
      check("post_rst_bus", bus_if.ms_to_ws_bus, 70'h0);

      // ALU pass-through
      present({1'b0, 1'b1, 5'd3, 32'h1234_5678}, 32'h1c00_0000, 5'b00000);
      step();
      idle();
      #1;
      check("alu_valid", bus_if.ms_to_ws_valid, 1'b1);
      check("alu_bus",   bus_if.ms_to_ws_bus, {1'b1, 5'd3, 32'h1234_5678, 32'h1c00_0000});
      check("alu_fwd",   bus_if.ms_rf_collect, {1'b1, 5'd3, 32'h1234_5678});
      step();
      check("alu_drain_valid", bus_if.ms_to_ws_valid, 1'b0);
      check("alu_drain_fwd_we", 70'(bus_if.ms_rf_collect[37]), 70'd0);

      // load alignment table
      for (int i = 0; i < 9; i++) begin
         present({1'b1, 1'b1, 5'd7, 30'h0000_0400, ld_off[i]}, 32'h1c00_0200 + 32'(i * 4), ld_inst[i]);
         bus_if.data_sram_rdata = 32'hDEAD_BEEF;
         step();
         idle();
         bus_if.data_sram_rdata = 32'h80FF_0011;
         #1;
         check($sformatf("load%0d_result", i), 70'(bus_if.ms_to_ws_bus[63:32]), 70'(ld_exp[i]));
         check($sformatf("load%0d_fwd", i), bus_if.ms_rf_collect, {1'b1, 5'd7, ld_exp[i]});
         step();
      end

      // stalled load keeps its first-cycle data
      bus_if.ws_allowin = 1'b0;
      present({1'b1, 1'b1, 5'd8, 32'h0000_2000}, 32'h1c00_0300, 5'b00001);
      step();
      idle();
      bus_if.data_sram_rdata = 32'hAAAA_AAAA;
      #1;
      check("stall_first_result", 70'(bus_if.ms_to_ws_bus[63:32]), 70'h0AAAA_AAAA);
      check("stall_first_allowin", bus_if.ms_allowin, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         bus_if.data_sram_rdata = 32'h5555_5555;
         present({1'b0, 1'b1, 5'd9, 32'h0000_0BAD}, 32'h1c00_0400, 5'b00000);
         #1;
         check($sformatf("stall%0d_result", k), 70'(bus_if.ms_to_ws_bus[63:32]), 70'h0AAAA_AAAA);
         check($sformatf("stall%0d_allowin", k), bus_if.ms_allowin, 1'b0);
         check($sformatf("stall%0d_pc", k), 70'(bus_if.ms_to_ws_bus[31:0]), 70'h01c00_0300);
         check($sformatf("stall%0d_valid", k), bus_if.ms_to_ws_valid, 1'b1);
      end
      idle();
      bus_if.ws_allowin = 1'b1;
      #1;
      check("stall_release_allowin", bus_if.ms_allowin, 1'b1);
      check("stall_release_result", 70'(bus_if.ms_to_ws_bus[63:32]), 70'h0AAAA_AAAA);
      step();
      check("stall_drained", bus_if.ms_to_ws_valid, 1'b0);

      // back-to-back loads; second must use its own first-cycle data
      present({1'b1, 1'b1, 5'd10, 32'h0000_3000}, 32'h1c00_0500, 5'b00001);
      bus_if.data_sram_rdata = 32'h0;
      step();
      present({1'b1, 1'b1, 5'd11, 32'h0000_3001}, 32'h1c00_0504, 5'b01000);
      bus_if.data_sram_rdata = 32'h1122_3344;
      #1;
      check("b2b_first_valid", bus_if.ms_to_ws_valid, 1'b1);
      check("b2b_first_bus", bus_if.ms_to_ws_bus, {1'b1, 5'd10, 32'h1122_3344, 32'h1c00_0500});
      step();
      idle();
      bus_if.data_sram_rdata = 32'h9988_7766;
      #1;
      check("b2b_second_valid", bus_if.ms_to_ws_valid, 1'b1);
      check("b2b_second_bus", bus_if.ms_to_ws_bus, {1'b1, 5'd11, 32'h0000_0077, 32'h1c00_0504});
      step();
      check("b2b_drained", bus_if.ms_to_ws_valid, 1'b0);

      // reset during a stall discards the instruction
      bus_if.ws_allowin = 1'b0;
      present({1'b0, 1'b1, 5'd9, 32'h0000_CAFE}, 32'h1c00_0600, 5'b00000);
      step();
      idle();
      #1;
      check("rst_stall_pre_valid", bus_if.ms_to_ws_valid, 1'b1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      #1;
      check("rst_stall_valid",   bus_if.ms_to_ws_valid, 1'b0);
      check("rst_stall_fwd",     bus_if.ms_rf_collect, 38'h0);
      check("rst_stall_allowin", bus_if.ms_allowin, 1'b1);
      check("rst_stall_bus",     bus_if.ms_to_ws_bus, 70'h0);

      // bubble must not forward a write-enable
      bus_if.ws_allowin    = 1'b1;
      idle();
      bus_if.es_rf_collect = {1'b0, 1'b1, 5'd5, 32'h0000_0077};
      step();
      check("bubble_fwd_we", 70'(bus_if.ms_rf_collect[37]), 70'd0);
      check("bubble_valid", bus_if.ms_to_ws_valid, 1'b0);
      step();
      check("bubble_fwd_we_2", 70'(bus_if.ms_rf_collect[37]), 70'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
